lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
Serial receive-side checker for the 10-bit Fibonacci LFSR stream produced by the team's LFSR generator (shift right, new bit = s[0]^s[3], output = s[0]).
- Self-synchronises to the incoming stream, declares lock, then free-runs its own copy of the sequence (flywheel).
- Flags and counts bit errors.
- Sits at the consumer end of the link or test path, driven one bit per cycle qualified by in_valid.

Parameters:
LOCK_MATCHES, 16, consecutive correct predictions required in VERIFY before declaring lock (>=1)
LOSS_THRESH, 4, consecutive mismatches in LOCKED that drop lock back to SEARCH (>=1)
CNT_W, 16, width of saturating error counter

Ports:
clock  input  1  system clock, all state updates on posedge
reset_n  input  1  synchronous active-low reset, sampled on posedge clock
in_valid  input  1  in_bit is a valid stream bit this cycle
in_bit  input  1  received serial bit
clear_n  input  1  synchronous active-low clear of err_count only
locked  output  1  registered; high while in LOCKED state
err_pulse  output  1  registered; one-cycle pulse per mismatched bit while LOCKED
err_count  output  CNT_W  registered saturating count of mismatches while LOCKED

Behaviour:
- Reset (reset_n low at posedge): state=SEARCH, history h[9:0]=0, fill=0, match_cnt=0, miss_cnt=0, locked=0, err_pulse=0, err_count=0. Overrides all other inputs, including mid-VERIFY or mid-LOCKED.
- in_valid low: no state change anywhere; err_pulse=0 next cycle.
- History register mirrors the generator's state: on an accepted bit x, h <= {x, h[9:1]}.
- Prediction for the next bit: p = h[0]^h[3].
- SEARCH:
  - Each valid bit shifts in_bit into h; fill increments.
  - On the 10th valid bit: go to VERIFY, match_cnt=0.
- VERIFY:
  - Each valid bit shifts in_bit (not p) into h, so the checker self-syncs.
  - in_bit==p and h!=0: match_cnt++.
  - in_bit!=p: match_cnt=0.
  - h==0: match_cnt held at 0. This blocks false lock on all-zero input.
  - When the accepted bit makes match_cnt reach LOCK_MATCHES: go to LOCKED, miss_cnt=0; locked=1 from the next cycle.
- LOCKED:
  - Each valid bit shifts p into h (flywheel), so errors do not propagate.
  - in_bit!=p: err_pulse=1 for exactly one cycle (the cycle after acceptance), err_count++ (saturates at all-ones), miss_cnt++.
  - in_bit==p: miss_cnt=0.
  - When miss_cnt reaches LOSS_THRESH: go to SEARCH with fill=0, h keeps its value, locked=0 next cycle. The bit that triggers this is still counted as an error.
- clear_n low: err_count=0 next cycle. If a mismatch occurs in the same cycle, clear wins (count=0, err_pulse still 1).
- Latency: input bit to err_pulse, err_count and locked update is 1 cycle. There are no combinational input-to-output paths.
- Minimum valid bits from reset to locked: 10 + LOCK_MATCHES (26 at defaults).

Decomposition:
- Shared package lfsr_pkg holds:
  - LFSR_W=10
  - tap indices TAP_A=0, TAP_B=3
  - the state encoding enum {SEARCH, VERIFY, LOCKED}

  The generator uses the same package, so the taps are defined in one place.
- One natural sub-module, lfsr_predict: combinational h -> p. It is reusable by the generator's feedback path.
- FSM, counters and history stay in lfsr_checker.

Test Plan:
1. Generator seeded 10'h001 feeds checker, in_valid=1 every cycle, 60 bits -> locked rises exactly after the 26th valid bit, err_count=0, err_pulse never high.
2. After lock, invert a single bit -> err_pulse high for 1 cycle, err_count=1, locked stays 1, no further pulses over the next 50 bits.
3. After lock, invert 4 consecutive bits -> err_count=4, locked falls after the 4th bit, checker relocks after 26 further valid bits, err_count stays 4.
4. Constant in_bit=0 for 200 valid cycles -> locked never asserts; the reverse case, 26 ones after reset, also never locks (1^1=0 mismatches).
5. in_valid toggled every other cycle with the test 1 stream -> lock after 26 valid bits (52 cycles); then clear_n low in the same cycle as an injected error -> err_count=0, err_pulse=1.
6. CNT_W=4, LOSS_THRESH=8: 20 isolated errors while locked -> err_count saturates at 15. Then reset_n low mid-stream for one cycle -> all outputs 0, lock requires a full 26 valid bits again.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 10-bit Fibonacci LFSR generator and checker.
// Taps live here so both ends of the link always agree on the polynomial.
package lfsr_pkg;

    localparam int unsigned LFSR_W = 10;
    localparam int unsigned TAP_A  = 0;
    localparam int unsigned TAP_B  = 3;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lfsr_state_e;

endpackage

// File: rtl/lfsr_predict.sv
// Combinational next-bit prediction from an LFSR state / history word.
// Also usable as the generator's feedback term.
module lfsr_predict
    import lfsr_pkg::*;
(
    input  logic [LFSR_W-1:0] hist,
    output logic              pred
);

    assign pred = hist[TAP_A] ^ hist[TAP_B];

endmodule

// File: rtl/lfsr_checker.sv
// Serial checker for the 10-bit Fibonacci LFSR stream. Fills a history
// register from the line, verifies a run of correct predictions, then
// flywheels its own copy of the sequence and counts mismatching bits.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned LOCK_MATCHES = 16,
    parameter int unsigned LOSS_THRESH  = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear_n,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned FILL_W  = $clog2(LFSR_W + 1);
    localparam int unsigned MATCH_W = $clog2(LOCK_MATCHES + 1);
    localparam int unsigned MISS_W  = $clog2(LOSS_THRESH + 1);

    lfsr_state_e        state_q, state_d;
    logic [LFSR_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d, match_inc;
    logic [MISS_W-1:0]  miss_q, miss_d, miss_inc;
    logic               locked_q, locked_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               pred;

    lfsr_predict u_predict (
        .hist (hist_q),
        .pred (pred)
    );

    // Counters never exceed their thresholds, so the increments cannot wrap.
    assign match_inc = match_q + 1'b1;
    assign miss_inc  = miss_q + 1'b1;

    // Next-state logic: search fill, self-synchronising verify, flywheel lock.
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_d   = 1'b0;
        count_d = count_q;

        if (in_valid) begin
            case (state_q)
                SEARCH: begin
                    hist_d = {in_bit, hist_q[LFSR_W-1:1]};
                    if (fill_q == FILL_W'(LFSR_W - 1)) begin
                        state_d = VERIFY;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                VERIFY: begin
                    // Shift the received bit so a wrong start heals itself.
                    hist_d = {in_bit, hist_q[LFSR_W-1:1]};
                    if (in_bit != pred || hist_q == '0) begin
                        // All-zero history predicts zeros forever; never count it.
                        match_d = '0;
                    end else if (match_inc == MATCH_W'(LOCK_MATCHES)) begin
                        state_d = LOCKED;
                        match_d = '0;
                        miss_d  = '0;
                    end else begin
                        match_d = match_inc;
                    end
                end
                LOCKED: begin
                    // Flywheel: shift the prediction so line errors do not propagate.
                    hist_d = {pred, hist_q[LFSR_W-1:1]};
                    if (in_bit != pred) begin
                        err_d = 1'b1;
                        if (count_q != '1) begin
                            count_d = count_q + 1'b1;
                        end
                        if (miss_inc == MISS_W'(LOSS_THRESH)) begin
                            state_d = SEARCH;
                            fill_d  = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    fill_d  = '0;
                end
            endcase
        end

        if (!clear_n) begin
            count_d = '0;
        end
        locked_d = (state_d == LOCKED);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= SEARCH;
            hist_q   <= '0;
            fill_q   <= '0;
            match_q  <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            count_q  <= count_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_q;
    assign err_count = count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: default instance plus a CNT_W=4,
// LOSS_THRESH=8 instance sharing the same stimulus.
module tb_lfsr_checker;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_bit;
    logic       clear_n;

    logic       a_locked, a_err_pulse;
    logic [15:0] a_err_count;
    logic       b_locked, b_err_pulse;
    logic [3:0] b_err_count;

    int checks = 0;
    int errors = 0;

    logic [9:0] gen_s;
    logic       seen_lock;

    lfsr_checker u_dut_a (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clear_n   (clear_n),
        .locked    (a_locked),
        .err_pulse (a_err_pulse),
        .err_count (a_err_count)
    );

    lfsr_checker #(
        .LOCK_MATCHES (16),
        .LOSS_THRESH  (8),
        .CNT_W        (4)
    ) u_dut_b (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clear_n   (clear_n),
        .locked    (b_locked),
        .err_pulse (b_err_pulse),
        .err_count (b_err_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of input, then sample 1 time unit after the edge.
    task automatic send(input logic v, input logic b);
        in_valid = v;
        in_bit   = b;
        @(posedge clock);
        #1;
    endtask

    // Send the next generator bit, optionally inverted on the line.
    task automatic send_gen(input logic inv);
        logic b;
        b     = gen_s[0] ^ inv;
        gen_s = {gen_s[0] ^ gen_s[3], gen_s[9:1]};
        send(1'b1, b);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        send(1'b0, 1'b0);
        send(1'b0, 1'b0);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        clear_n  = 1'b1;
        gen_s    = 10'h001;

        // Reset state
        do_reset();
        check("rst_locked", 32'(a_locked), 32'd0);
        check("rst_pulse", 32'(a_err_pulse), 32'd0);
        check("rst_count", 32'(a_err_count), 32'd0);

        // 1: clean stream, lock exactly after 26th valid bit
        gen_s = 10'h001;
        for (int i = 1; i <= 60; i++) begin
            send_gen(1'b0);
            check("t1_locked", 32'(a_locked), 32'(i >= 26));
            check("t1_pulse", 32'(a_err_pulse), 32'd0);
        end
        check("t1_count", 32'(a_err_count), 32'd0);
        check("t1_b_locked", 32'(b_locked), 32'd1);

        // 2: single inverted bit
        send_gen(1'b1);
        check("t2_pulse", 32'(a_err_pulse), 32'd1);
        check("t2_count", 32'(a_err_count), 32'd1);
        check("t2_locked", 32'(a_locked), 32'd1);
        for (int i = 0; i < 50; i++) begin
            send_gen(1'b0);
            check("t2_quiet", 32'(a_err_pulse), 32'd0);
        end
        check("t2_count_hold", 32'(a_err_count), 32'd1);
        check("t2_locked_hold", 32'(a_locked), 32'd1);

        // Clear with in_valid low
        clear_n = 1'b0;
        send(1'b0, 1'b0);
        clear_n = 1'b1;
        check("clr_count", 32'(a_err_count), 32'd0);
        check("clr_locked", 32'(a_locked), 32'd1);

        // 3: four consecutive errors drop lock, then relock after 26 bits
        for (int k = 1; k <= 4; k++) begin
            send_gen(1'b1);
            check("t3_pulse", 32'(a_err_pulse), 32'd1);
            check("t3_count", 32'(a_err_count), 32'(k));
            check("t3_locked", 32'(a_locked), 32'(k < 4));
        end
        check("t3_b_locked", 32'(b_locked), 32'd1);
        for (int j = 1; j <= 30; j++) begin
            send_gen(1'b0);
            check("t3_relock", 32'(a_locked), 32'(j >= 26));
            check("t3_pulse0", 32'(a_err_pulse), 32'd0);
        end
        check("t3_count_hold", 32'(a_err_count), 32'd4);

        // 4a: all zeros never lock
        do_reset();
        seen_lock = 1'b0;
        for (int i = 0; i < 200; i++) begin
            send(1'b1, 1'b0);
            seen_lock = seen_lock | a_locked;
        end
        check("t4_zeros", 32'(seen_lock), 32'd0);

        // 4b: all ones never lock
        do_reset();
        seen_lock = 1'b0;
        for (int i = 0; i < 40; i++) begin
            send(1'b1, 1'b1);
            seen_lock = seen_lock | a_locked;
        end
        check("t4_ones", 32'(seen_lock), 32'd0);

        // 5: valid every other cycle, junk on the line while invalid
        do_reset();
        gen_s = 10'h001;
        for (int i = 1; i <= 26; i++) begin
            send(1'b0, ~gen_s[0]);
            check("t5_idle_locked", 32'(a_locked), 32'd0);
            send_gen(1'b0);
            check("t5_locked", 32'(a_locked), 32'(i >= 26));
        end
        for (int i = 0; i < 5; i++) send_gen(1'b0);
        send_gen(1'b1);
        check("t5_err_pulse", 32'(a_err_pulse), 32'd1);
        check("t5_err_count", 32'(a_err_count), 32'd1);
        send(1'b0, 1'b0);
        check("t5_idle_pulse", 32'(a_err_pulse), 32'd0);
        check("t5_idle_count", 32'(a_err_count), 32'd1);
        for (int i = 0; i < 3; i++) send_gen(1'b0);
        clear_n = 1'b0;
        send_gen(1'b1);
        clear_n = 1'b1;
        check("t5_clr_pulse", 32'(a_err_pulse), 32'd1);
        check("t5_clr_count", 32'(a_err_count), 32'd0);
        send_gen(1'b0);
        check("t5_after_pulse", 32'(a_err_pulse), 32'd0);
        check("t5_after_count", 32'(a_err_count), 32'd0);
        check("t5_after_locked", 32'(a_locked), 32'd1);

        // 6: saturation in the narrow instance, then mid-stream reset
        do_reset();
        gen_s = 10'h001;
        for (int i = 1; i <= 26; i++) begin
            send_gen(1'b0);
            check("t6_b_locked", 32'(b_locked), 32'(i >= 26));
        end
        for (int k = 1; k <= 20; k++) begin
            send_gen(1'b1);
            check("t6_b_pulse", 32'(b_err_pulse), 32'd1);
            check("t6_b_count", 32'(b_err_count), 32'((k > 15) ? 15 : k));
            send_gen(1'b0);
            send_gen(1'b0);
        end
        check("t6_a_count", 32'(a_err_count), 32'd20);
        check("t6_a_locked", 32'(a_locked), 32'd1);
        check("t6_b_still_locked", 32'(b_locked), 32'd1);

        reset_n = 1'b0;
        send_gen(1'b1);
        reset_n = 1'b1;
        check("t6_rst_b_locked", 32'(b_locked), 32'd0);
        check("t6_rst_b_pulse", 32'(b_err_pulse), 32'd0);
        check("t6_rst_b_count", 32'(b_err_count), 32'd0);
        check("t6_rst_a_locked", 32'(a_locked), 32'd0);
        check("t6_rst_a_count", 32'(a_err_count), 32'd0);
        for (int j = 1; j <= 30; j++) begin
            send_gen(1'b0);
            check("t6_relock", 32'(b_locked), 32'(j >= 26));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
